// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control encodings, hazard FSM states and register-index width
package pipe_ctrl_pkg;
  localparam int REG_AW = 5;
  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  typedef enum logic [1:0] {HZ_RUN, HZ_LU_STALL, HZ_FLUSH} hz_state_e;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating 32-bit stall/flush cycle counter pair, cleared by rst
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  logic [31:0] stall_q, stall_d, flush_q, flush_d;
  // count each qualifying cycle, holding at all-ones instead of wrapping
  always_comb begin
    stall_d = (stall_inc && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    flush_d = (flush_inc && flush_q != '1) ? flush_q + 32'd1 : flush_q;
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall / taken-branch flush control; HAZARD_PERF_CNT_EN adds perf counters
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic [1:0]        ex_wbsel,
  input  logic              ex_branch_taken,
  output logic              bubble_sel,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              if_id_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);
  if (LOAD_STALL < 1 || LOAD_STALL > 7) begin : g_ls_chk
    $error("LOAD_STALL must be in 1..7");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_fc_chk
    $error("FLUSH_CYCLES must be in 1..3");
  end
  localparam logic [2:0] LS_INIT = (LOAD_STALL > 1) ? 3'(LOAD_STALL - 2) : 3'd0;
  localparam logic [2:0] FL_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
  localparam logic [3:0] O_RUN = 4'b0110;
  localparam logic [3:0] O_STALL = 4'b1000;
  localparam logic [3:0] O_FLUSH = 4'b1111;
  localparam logic [3:0] O_RST = 4'b1001;
  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lu;
  logic [3:0] outs;
  // load-use: EX holds a load whose destination the ID instruction reads (x0 never hazards)
  always_comb begin
    lu = ex_regwrite && ex_wbsel == WB_MEM && ex_rd != '0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  end
  // next state and outputs: Mealy in RUN, Moore while stalling or flushing; reset overrides outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    outs    = O_RUN;
    case (state_q)
      HZ_RUN: begin
        if (ex_branch_taken) begin
          outs = O_FLUSH;
          if (FLUSH_CYCLES > 1) begin
            state_d = HZ_FLUSH;
            cnt_d   = FL_INIT;
          end
        end else if (lu) begin
          outs = O_STALL;
          if (LOAD_STALL > 1) begin
            state_d = HZ_LU_STALL;
            cnt_d   = LS_INIT;
          end
        end
      end
      HZ_LU_STALL: begin
        outs    = O_STALL;
        state_d = (cnt_q == '0) ? HZ_RUN : HZ_LU_STALL;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 3'd1;
      end
      HZ_FLUSH: begin
        outs    = O_FLUSH;
        state_d = (cnt_q == '0) ? HZ_RUN : HZ_FLUSH;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 3'd1;
      end
      default: state_d = HZ_RUN;
    endcase
    if (rst) outs = O_RST;
  end
  // state and countdown registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign {bubble_sel, pc_we, if_id_we, if_id_flush} = outs;
`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .stall_inc (!rst && !pc_we),
    .flush_inc (!rst && if_id_flush),
    .stall_cnt (perf_stall_cnt),
    .flush_cnt (perf_flush_cnt)
  );
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: table vectors, corner sequences and randomized checks against a cycle-count model
module tb_hazard_stall_ctrl;
  localparam int N = 4;
  localparam int LS[N] = '{1, 3, 2, 7};
  localparam int FC[N] = '{2, 2, 1, 3};
  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic [1:0] wb;
    logic       br;
    logic [3:0] exp;
  } vec_t;
  logic clk = 0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_regwrite, ex_branch_taken;
  logic [1:0] ex_wbsel;
  logic bub[N], pcwe[N], ifwe[N], ifl[N];
  logic [31:0] pst[N], pfl[N];
  int tests = 0, fails = 0;
  int sl[N], fl[N];
  longint ps[N], pf[N];
  vec_t tbl[18];
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    hazard_stall_ctrl #(.LOAD_STALL(LS[g]), .FLUSH_CYCLES(FC[g])) u_dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_wbsel(ex_wbsel), .ex_branch_taken(ex_branch_taken),
      .bubble_sel(bub[g]), .pc_we(pcwe[g]), .if_id_we(ifwe[g]), .if_id_flush(ifl[g])
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cnt(pst[g]), .perf_flush_cnt(pfl[g])
`endif
    );
`ifndef HAZARD_PERF_CNT_EN
    assign pst[g] = '0;
    assign pfl[g] = '0;
`endif
  end
  function automatic vec_t mk(logic r, logic [4:0] a, logic [4:0] b, logic ua, logic ub,
                              logic [4:0] d, logic w, logic [1:0] s, logic t, logic [3:0] e);
    vec_t v;
    v.rst = r; v.rs1 = a; v.rs2 = b; v.u1 = ua; v.u2 = ub;
    v.rd = d; v.rw = w; v.wb = s; v.br = t; v.exp = e;
    return v;
  endfunction
  function automatic logic hazard();
    return ex_regwrite && ex_wbsel == 2'b00 && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction
  // remaining-cycle model: a hazard books LS cycles of stall, a branch books FC cycles of flush
  function automatic logic [3:0] model_out(int i);
    if (rst) return 4'b1001;
    if (sl[i] > 0) return 4'b1000;
    if (fl[i] > 0) return 4'b1111;
    if (ex_branch_taken) return 4'b1111;
    if (hazard()) return 4'b1000;
    return 4'b0110;
  endfunction
  function automatic logic [3:0] dut_out(int i);
    return {bub[i], pcwe[i], ifwe[i], ifl[i]};
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic apply(logic r, logic [4:0] a, logic [4:0] b, logic ua, logic ub,
                       logic [4:0] d, logic w, logic [1:0] s, logic t);
    rst = r; id_rs1 = a; id_rs2 = b; id_use_rs1 = ua; id_use_rs2 = ub;
    ex_rd = d; ex_regwrite = w; ex_wbsel = s; ex_branch_taken = t;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("model_out[%0d]", i), 32'(dut_out(i)), 32'(model_out(i)));
`ifdef HAZARD_PERF_CNT_EN
      chk($sformatf("perf_stall[%0d]", i), pst[i], 32'(ps[i]));
      chk($sformatf("perf_flush[%0d]", i), pfl[i], 32'(pf[i]));
`endif
    end
  endtask
  task automatic tick();
    logic [3:0] o[N];
    for (int i = 0; i < N; i++) o[i] = model_out(i);
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        sl[i] = 0; fl[i] = 0; ps[i] = 0; pf[i] = 0;
      end else begin
        if (!o[i][2] && ps[i] < 64'hFFFF_FFFF) ps[i]++;
        if (o[i][0] && pf[i] < 64'hFFFF_FFFF) pf[i]++;
        if (sl[i] > 0) sl[i]--;
        else if (fl[i] > 0) fl[i]--;
        else if (ex_branch_taken) fl[i] = FC[i] - 1;
        else if (hazard()) sl[i] = LS[i] - 1;
      end
    end
    @(negedge clk);
  endtask
  task automatic idle(logic r);
    apply(r, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 2'b01, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin sl[i] = 0; fl[i] = 0; ps[i] = 0; pf[i] = 0; end
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 2'b01, 1, 4'b1001);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 2'b01, 1, 4'b1001);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 2'b01, 1, 4'b1001);
    tbl[3]  = mk(0, 1, 2, 1, 1, 3, 1, 2'b01, 0, 4'b0110);
    tbl[4]  = mk(0, 0, 5, 0, 1, 5, 1, 2'b00, 0, 4'b1000);
    tbl[5]  = mk(0, 1, 2, 1, 1, 3, 1, 2'b01, 0, 4'b0110);
    tbl[6]  = mk(0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 4'b0110);
    tbl[7]  = mk(0, 0, 5, 0, 1, 5, 1, 2'b01, 0, 4'b0110);
    tbl[8]  = mk(0, 7, 0, 1, 0, 7, 1, 2'b00, 0, 4'b1000);
    tbl[9]  = mk(0, 7, 0, 0, 0, 7, 1, 2'b00, 0, 4'b0110);
    tbl[10] = mk(0, 0, 5, 0, 1, 5, 1, 2'b00, 1, 4'b1111);
    tbl[11] = mk(0, 0, 5, 0, 1, 5, 1, 2'b00, 0, 4'b1111);
    tbl[12] = mk(0, 0, 5, 0, 1, 5, 1, 2'b00, 0, 4'b1000);
    tbl[13] = mk(0, 9, 0, 1, 0, 9, 1, 2'b00, 0, 4'b1000);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 4'b1111);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 4'b1001);
    tbl[16] = mk(0, 1, 2, 1, 1, 3, 1, 2'b01, 0, 4'b0110);
    tbl[17] = mk(0, 0, 5, 0, 1, 5, 0, 2'b00, 0, 4'b0110);
    rst = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_regwrite = 0; ex_wbsel = 2'b01; ex_branch_taken = 0;
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      apply(tbl[k].rst, tbl[k].rs1, tbl[k].rs2, tbl[k].u1, tbl[k].u2,
            tbl[k].rd, tbl[k].rw, tbl[k].wb, tbl[k].br);
      chk($sformatf("vec%0d", k), 32'(dut_out(0)), 32'(tbl[k].exp));
      tick();
    end
    apply(0, 7, 0, 1, 0, 7, 1, 2'b00, 0);
    chk("ls3_stall1", 32'(dut_out(1)), 32'h8);
    tick();
    for (int k = 2; k <= 3; k++) begin
      idle(0);
      chk($sformatf("ls3_stall%0d", k), 32'(dut_out(1)), 32'h8);
      tick();
    end
    idle(0);
    chk("ls3_release", 32'(dut_out(1)), 32'h6);
    tick();
    apply(0, 7, 0, 1, 0, 7, 1, 2'b00, 0);
    chk("ls7_stall1", 32'(dut_out(3)), 32'h8);
    tick();
    idle(1);
    chk("mid_stall_rst", 32'(dut_out(3)), 32'h9);
    tick();
    idle(0);
    chk("after_rst_ls7", 32'(dut_out(3)), 32'h6);
    chk("after_rst_ls3", 32'(dut_out(1)), 32'h6);
    tick();
    apply(0, 0, 5, 0, 1, 5, 1, 2'b00, 1);
    chk("fc1_flush", 32'(dut_out(2)), 32'hF);
    chk("fc3_flush1", 32'(dut_out(3)), 32'hF);
    tick();
    idle(0);
    chk("fc1_done", 32'(dut_out(2)), 32'h6);
    chk("fc3_flush2", 32'(dut_out(3)), 32'hF);
    tick();
    idle(0);
    chk("fc3_flush3", 32'(dut_out(3)), 32'hF);
    tick();
    idle(0);
    chk("fc3_done", 32'(dut_out(3)), 32'h6);
    tick();
    for (int k = 0; k < 3000; k++) begin
      apply(logic'($urandom_range(0, 39) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            2'($urandom_range(0, 2)), logic'($urandom_range(0, 7) == 0));
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
